// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle for the iterative RV32M multiply/divide unit.
//   master: start, flush, md_op, operand_a, operand_b out; busy, done, result in
//   slave : the mirror image, used by muldiv_unit
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      md_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, md_op, operand_a, operand_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, md_op, operand_a, operand_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M engine. Shift-add multiply / restoring divide over
// XLEN cycles, with divide-by-zero and signed overflow resolved in one cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_unit_if.slave (start/flush/md_op/operands in; busy/done/result out)
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned PW = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   count_q, count_n;
    logic [2:0]      op_q, op_n;
    logic            neg_q, neg_n;
    logic [PW-1:0]   prod_q, prod_n;
    logic [PW-1:0]   mcand_q, mcand_n;
    logic [XLEN-1:0] mplier_q, mplier_n;
    logic [XLEN-1:0] rem_q, rem_n;
    logic [XLEN-1:0] quot_q, quot_n;
    logic [XLEN-1:0] divisor_q, divisor_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic [XLEN-1:0] result_q, result_n;

    // Operand decode at the request: signedness, signs and magnitudes
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        a_signed = (bus.md_op == OP_MULH) || (bus.md_op == OP_MULHSU) ||
                   (bus.md_op == OP_DIV)  || (bus.md_op == OP_REM);
        b_signed = (bus.md_op == OP_MULH) || (bus.md_op == OP_DIV) ||
                   (bus.md_op == OP_REM);
        sign_a   = a_signed && bus.operand_a[XLEN-1];
        sign_b   = b_signed && bus.operand_b[XLEN-1];
        mag_a    = sign_a ? (XLEN'(0) - bus.operand_a) : bus.operand_a;
        mag_b    = sign_b ? (XLEN'(0) - bus.operand_b) : bus.operand_b;
    end

    // One datapath iteration plus the sign-corrected selection used on the last one
    logic [PW-1:0]   prod_step, prod_fin;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] rem_step, quot_step, rem_fin, quot_fin, sel;

    always_comb begin
        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        shifted   = {rem_q, quot_q[XLEN-1]};
        if (shifted >= {1'b0, divisor_q}) begin
            rem_step  = XLEN'(shifted - {1'b0, divisor_q});
            quot_step = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step  = shifted[XLEN-1:0];
            quot_step = {quot_q[XLEN-2:0], 1'b0};
        end
        prod_fin = neg_q ? (PW'(0) - prod_step) : prod_step;
        quot_fin = neg_q ? (XLEN'(0) - quot_step) : quot_step;
        rem_fin  = neg_q ? (XLEN'(0) - rem_step) : rem_step;
        case (op_q)
            OP_MUL:                      sel = prod_fin[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sel = prod_fin[PW-1:XLEN];
            OP_DIV, OP_DIVU:             sel = quot_fin;
            default:                     sel = rem_fin;
        endcase
    end

    // Next-state and register updates
    always_comb begin
        state_n   = state_q;
        count_n   = count_q;
        op_n      = op_q;
        neg_n     = neg_q;
        prod_n    = prod_q;
        mcand_n   = mcand_q;
        mplier_n  = mplier_q;
        rem_n     = rem_q;
        quot_n    = quot_q;
        divisor_n = divisor_q;
        result_n  = result_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_n      = bus.md_op;
                    // Remainder takes the dividend's sign; everything else the XOR
                    neg_n     = (bus.md_op[2] && bus.md_op[1]) ? sign_a : (sign_a ^ sign_b);
                    count_n   = '0;
                    prod_n    = '0;
                    mcand_n   = {{XLEN{1'b0}}, mag_a};
                    mplier_n  = mag_b;
                    rem_n     = '0;
                    quot_n    = mag_a;
                    divisor_n = mag_b;
                    if (bus.md_op[2] && (bus.operand_b == '0)) begin
                        result_n = bus.md_op[1] ? bus.operand_a : ALL_ONES;
                        state_n  = DONE;
                    end else if (bus.md_op[2] && !bus.md_op[0] &&
                                 (bus.operand_a == MIN_NEG) && (bus.operand_b == ALL_ONES)) begin
                        result_n = bus.md_op[1] ? '0 : MIN_NEG;
                        state_n  = DONE;
                    end else begin
                        state_n  = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_n = IDLE;
                end else begin
                    prod_n   = prod_step;
                    mcand_n  = mcand_q << 1;
                    mplier_n = mplier_q >> 1;
                    rem_n    = rem_step;
                    quot_n   = quot_step;
                    count_n  = count_q + CW'(1);
                    if (count_q == CW'(XLEN - 1)) begin
                        result_n = sel;
                        state_n  = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            op_q      <= op_n;
            neg_q     <= neg_n;
            prod_q    <= prod_n;
            mcand_q   <= mcand_n;
            mplier_q  <= mplier_n;
            rem_q     <= rem_n;
            quot_q    <= quot_n;
            divisor_q <= divisor_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            result_q  <= result_n;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle RV32M multiply/divide engine in the EX stage, alongside the single-cycle ALU.
- Accepts one operation on a start pulse and runs a shift-add multiply or restoring divide over XLEN cycles.
- Holds `busy` so the hazard logic stalls IF/ID/EX, then presents the result with a one-cycle `done` pulse.
- The pipeline flush path can abort an in-flight operation.

Parameters:
- XLEN, 32, operand/result width; the counter is $clog2(XLEN)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  synchronous abort; has priority over start
- md_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand_a  input  XLEN  rs1 value, sampled with start
- operand_b  input  XLEN  rs2 value, sampled with start
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  final value; held until the next accepted start

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, result=0.
  - Counter and internal registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 and flush=0 at edge E0, latch md_op.
  - Latch |a| and |b| as unsigned magnitudes: MULH/DIV/REM treat both operands as signed; MULHSU treats only a as signed.
  - Record the result sign: MUL* uses sign_a XOR sign_b; DIV uses sign_a XOR sign_b; REM uses sign_a.
  - Go to RUN with count=0.
- Special cases, decided at E0, go straight to DONE with no RUN:
  - Divide by zero (b==0, ops 4-7): quotient = all ones; remainder = operand_a unchanged.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
  - done is asserted in the cycle after E0.
- RUN, one iteration per cycle, count increments:
  - Multiply: if multiplier LSB is set, add the multiplicand into the 2*XLEN accumulator; shift the multiplier right and the multiplicand left.
  - Divide: shift {rem,quot} left by 1; if rem >= |b|, subtract and set quot[0].
  - After the iteration with count==XLEN-1 (edge E_XLEN), go to DONE.
- DONE entry (edge E_XLEN):
  - Apply sign correction (two's-complement negate of the full 2*XLEN product, or of the quotient/remainder).
  - Select the output: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the selection into result.
- DONE: done=1 for exactly one cycle, then IDLE next edge. The normal path gives done high in the cycle after edge E_XLEN (XLEN cycles after start).
- busy:
  - Rises in the cycle after E0.
  - Falls in the cycle after DONE, so busy and done overlap for one cycle.
- start while busy=1 is ignored; no queuing.
- flush=1 in RUN or DONE: next edge goes to IDLE with done=0 and result unchanged.
- flush=1 in IDLE blocks start.
- start and flush in the same IDLE cycle: flush wins; no operation begins.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). No exceptions are raised.
- rst asserted mid-RUN: immediate return to the reset state; the partial result is discarded.

Test Plan:
- MUL 7*6 (a=7, b=6, md_op=0): done exactly 32 cycles after the start edge; result=42; busy high for 33 cycles.
- MULH signed (a=0xFFFFFFFF, b=0xFFFFFFFF): result=0. MULHU with the same operands: result=0xFFFFFFFE. MULHSU (a=-1, b=2): result=0xFFFFFFFF.
- DIV -7/2: result=0xFFFFFFFD (-3). REM -7/2: result=0xFFFFFFFF (-1). DIVU 100/7: result=14. REMU 100/7: result=2.
- Divide by zero, DIV 5/0: done the cycle after start, result=0xFFFFFFFF. REM 5/0: result=5. Overflow DIV 0x80000000/-1: result=0x80000000 in 1 cycle.
- flush at RUN count=10: done never pulses and busy drops after the next edge. A new start immediately after produces a correct result. A start pulse during RUN is ignored (done pulses once only).
- rst asserted mid-RUN: busy, done and result go to 0 immediately (asynchronously). After rst is released, MULHU 0x10000*0x10000 gives result=1.
